// File: rtl/digit_disp_pkg.sv
// ============================================================================
// Module : digit_disp_pkg
// Shared digit-display constants, FSM encoding and slot-range helper.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package digit_disp_pkg;

  localparam int unsigned N_DIGITS = 11;
  localparam int unsigned DIGIT_W  = 4;
  localparam logic [3:0]  BLANK_CODE = 4'hA;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_WAIT_VS = 1'b1;

  function automatic logic slot_in_range(input logic [3:0] idx, input int unsigned n);
    return 32'(idx) < n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vsync_edge_det.sv
// ============================================================================
// Module : vsync_edge_det
// Falling-edge detector for the active-low frame sync.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module vsync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic v_sync,
  output logic vs_fall
);

  logic r_vs_q;

  // Resets high so a sync held low through reset is not mistaken for an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_vs_q <= 1'b1;
    else      r_vs_q <= v_sync;
  end

  assign vs_fall = r_vs_q & ~v_sync;

endmodule

`default_nettype wire

// File: rtl/digit_frame_loader.sv
// ============================================================================
// Module : digit_frame_loader
// Shadow-buffered digit loader; commits to num_data only on a v_sync fall.
// Optional blink of one slot when DIGIT_BLINK_EN is defined.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module digit_frame_loader
    import digit_disp_pkg::*;
#(
    parameter int unsigned N_DIGITS = digit_disp_pkg::N_DIGITS,
    parameter int unsigned DIGIT_W  = digit_disp_pkg::DIGIT_W,
    parameter logic [DIGIT_W-1:0] BLANK_CODE = digit_disp_pkg::BLANK_CODE,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [3:0]                   wr_idx,
    input  logic [DIGIT_W-1:0]           wr_digit,
    input  logic                         wr_last,
    input  logic                         clr,
    input  logic                         v_sync,
`ifdef DIGIT_BLINK_EN
    input  logic [3:0]                   blink_idx,
`endif
    output logic [N_DIGITS*DIGIT_W-1:0]  num_data,
    output logic                         done,
    output logic                         err
);

    localparam int unsigned NUM_W = N_DIGITS * DIGIT_W;

    logic [0:0]          r_state;
    logic [0:0]          w_state_nx;
    logic                w_vs_fall;
    logic                w_accept;
    logic                w_clr;
    logic                w_commit;
    logic [N_DIGITS-1:0] w_wr_en;
    logic [DIGIT_W-1:0]  r_shadow [N_DIGITS];
    logic [NUM_W-1:0]    w_shadow_flat;
    logic [NUM_W-1:0]    r_commit;
    logic                r_done;
    logic                r_err;

    vsync_edge_det u_vs_det (
        .clk     (clk),
        .rst     (rst),
        .v_sync  (v_sync),
        .vs_fall (w_vs_fall)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE:    if (w_accept && wr_last) w_state_nx = ST_WAIT_VS;
            ST_WAIT_VS: if (w_vs_fall)           w_state_nx = ST_IDLE;
            default:                             w_state_nx = ST_IDLE;
        endcase
    end

    // clr only acts in IDLE and masks the write handshake there.
    always_comb begin
        wr_ready = 1'b0;
        w_clr    = 1'b0;
        w_commit = 1'b0;
        case (r_state)
            ST_IDLE: begin
                wr_ready = ~clr;
                w_clr    = clr;
            end
            ST_WAIT_VS: w_commit = w_vs_fall;
            default: ;
        endcase
    end

    assign w_accept = wr_valid & wr_ready;

    generate
        for (genvar k = 0; k < int'(N_DIGITS); k++) begin : g_slot
            assign w_wr_en[k] = w_accept & (wr_idx == 4'(k));
            assign w_shadow_flat[k*DIGIT_W +: DIGIT_W] = r_shadow[k];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < int'(N_DIGITS); k++) r_shadow[k] <= BLANK_CODE;
        end else begin
            for (int k = 0; k < int'(N_DIGITS); k++) begin
                if (w_clr)           r_shadow[k] <= BLANK_CODE;
                else if (w_wr_en[k]) r_shadow[k] <= wr_digit;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_commit <= {N_DIGITS{BLANK_CODE}};
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= w_commit;
            if (w_commit) r_commit <= w_shadow_flat;
            if (w_clr)
                r_err <= 1'b0;
            else if (w_accept && !slot_in_range(wr_idx, N_DIGITS))
                r_err <= 1'b1;
        end
    end

    assign done = r_done;
    assign err  = r_err;

`ifdef DIGIT_BLINK_EN
    localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CNT_W-1:0] r_frame_cnt;
    logic             r_blink_on;
    logic [3:0]       r_blink_idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame_cnt <= '0;
            r_blink_on  <= 1'b1;
            r_blink_idx <= 4'hF;
        end else begin
            r_blink_idx <= blink_idx;
            if (w_vs_fall) begin
                if (r_frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
                    r_frame_cnt <= '0;
                    r_blink_on  <= ~r_blink_on;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end
            end
        end
    end

    // Blanking sits after the commit register so the shadow keeps the real digit.
    generate
        for (genvar k = 0; k < int'(N_DIGITS); k++) begin : g_blink
            assign num_data[k*DIGIT_W +: DIGIT_W] =
                (!r_blink_on && (r_blink_idx == 4'(k))) ? BLANK_CODE
                                                        : r_commit[k*DIGIT_W +: DIGIT_W];
        end
    endgenerate
`else
    assign num_data = r_commit;
`endif

endmodule

`default_nettype wire

// File: tb/tb_digit_frame_loader.sv
// ============================================================================
// Module : tb_digit_frame_loader
// Directed bench for digit_frame_loader with hand-computed expected values.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_digit_frame_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid;
    logic        wr_ready;
    logic [3:0]  wr_idx;
    logic [3:0]  wr_digit;
    logic        wr_last;
    logic        clr;
    logic        v_sync;
    logic [43:0] num_data;
    logic        done;
    logic        err;
`ifdef DIGIT_BLINK_EN
    logic [3:0]  blink_idx;
`endif

    int errors = 0;
    int checks = 0;

    localparam logic [43:0] ALL_A = 44'hAAAAAAAAAAA;

    always #5 clk = ~clk;

    digit_frame_loader #(.BLINK_FRAMES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_idx    (wr_idx),
        .wr_digit  (wr_digit),
        .wr_last   (wr_last),
        .clr       (clr),
        .v_sync    (v_sync),
`ifdef DIGIT_BLINK_EN
        .blink_idx (blink_idx),
`endif
        .num_data  (num_data),
        .done      (done),
        .err       (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic write(input logic [3:0] idx, input logic [3:0] dig, input logic last);
        wr_valid = 1'b1;
        wr_idx   = idx;
        wr_digit = dig;
        wr_last  = last;
        tick();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic frame();
        v_sync = 1'b0;
        tick();
        v_sync = 1'b1;
        tick();
    endtask

    initial begin
        rst = 1'b0; wr_valid = 1'b0; wr_idx = '0; wr_digit = '0; wr_last = 1'b0;
        clr = 1'b0; v_sync = 1'b1;
`ifdef DIGIT_BLINK_EN
        blink_idx = 4'hF;
`endif
        repeat (3) tick();
        rst = 1'b1;
        #1;

        // Reset state
        check("rst_num_data", 64'(num_data), 64'(ALL_A));
        check("rst_wr_ready", 64'(wr_ready), 64'd1);
        check("rst_done",     64'(done),     64'd0);
        check("rst_err",      64'(err),      64'd0);

        // Full frame write, commit on next v_sync fall
        for (int i = 0; i < 11; i++)
            write(4'(i), (i == 10) ? 4'hA : 4'(i), i == 10);
        check("wait_ready_low",  64'(wr_ready), 64'd0);
        check("wait_hold_num",   64'(num_data), 64'(ALL_A));
        tick(); tick();
        check("wait_hold_num2",  64'(num_data), 64'(ALL_A));
        check("wait_no_done",    64'(done),     64'd0);
        v_sync = 1'b0;
        tick();
        check("commit_num",      64'(num_data), 64'(44'hA9876543210));
        check("commit_done",     64'(done),     64'd1);
        v_sync = 1'b1;
        tick();
        check("done_one_cycle",  64'(done),     64'd0);
        check("idle_ready",      64'(wr_ready), 64'd1);

        // wr_last on the same edge as vs_fall: no commit until next frame
        v_sync = 1'b0;
        write(4'd0, 4'd5, 1'b1);
        v_sync = 1'b1;
        check("same_edge_no_done", 64'(done),     64'd0);
        check("same_edge_num",     64'(num_data), 64'(44'hA9876543210));
        check("same_edge_waiting", 64'(wr_ready), 64'd0);
        tick(); tick();
        check("same_edge_still",   64'(done),     64'd0);
        v_sync = 1'b0;
        tick();
        check("next_frame_num",    64'(num_data), 64'(44'hA9876543215));
        check("next_frame_done",   64'(done),     64'd1);
        v_sync = 1'b1;
        tick();

        // Out-of-range index: dropped, err sticky, handshake completes
        wr_valid = 1'b1; wr_idx = 4'd12; wr_digit = 4'd3; wr_last = 1'b1;
        #1;
        check("oob_ready",       64'(wr_ready), 64'd1);
        tick();
        wr_valid = 1'b0; wr_last = 1'b0;
        check("oob_err",         64'(err),      64'd1);
        check("oob_to_wait",     64'(wr_ready), 64'd0);
        v_sync = 1'b0;
        tick();
        check("oob_shadow_same", 64'(num_data), 64'(44'hA9876543215));
        check("oob_commit_done", 64'(done),     64'd1);
        v_sync = 1'b1;
        tick();
        check("err_sticky",      64'(err),      64'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_err",         64'(err),      64'd0);

        // clr beats wr_valid
        clr = 1'b1; wr_valid = 1'b1; wr_idx = 4'd2; wr_digit = 4'd9; wr_last = 1'b1;
        #1;
        check("clr_blocks_ready", 64'(wr_ready), 64'd0);
        tick();
        clr = 1'b0; wr_valid = 1'b0; wr_last = 1'b0;
        #1;
        check("clr_stay_idle",    64'(wr_ready), 64'd1);
        write(4'd4, 4'd7, 1'b1);
        v_sync = 1'b0;
        tick();
        check("clr_commit_num",   64'(num_data), 64'(44'hAAAAAA7AAAA));
        v_sync = 1'b1;
        tick();

        // Reset during WAIT_VS
        write(4'd1, 4'd6, 1'b1);
        check("pre_rst_wait",    64'(wr_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("async_rst_num",   64'(num_data), 64'(ALL_A));
        check("async_rst_idle",  64'(wr_ready), 64'd1);
        tick();
        rst = 1'b1;
        tick();
        v_sync = 1'b0;
        tick();
        check("post_rst_no_done", 64'(done),     64'd0);
        check("post_rst_num",     64'(num_data), 64'(ALL_A));
        v_sync = 1'b1;
        tick();
        check("post_rst_no_done2", 64'(done),    64'd0);

`ifdef DIGIT_BLINK_EN
        // Blink with BLINK_FRAMES=2, counting frames from a fresh reset
        rst = 1'b0;
        tick();
        rst = 1'b1;
        blink_idx = 4'd3;
        write(4'd3, 4'd2, 1'b1);
        frame();
        check("blink_f1_on",  64'(num_data), 64'(44'hAAAAAAA2AAA));
        frame();
        check("blink_f2_off", 64'(num_data), 64'(ALL_A));
        frame();
        check("blink_f3_off", 64'(num_data), 64'(ALL_A));
        frame();
        check("blink_f4_on",  64'(num_data), 64'(44'hAAAAAAA2AAA));
        frame();
        check("blink_f5_on",  64'(num_data), 64'(44'hAAAAAAA2AAA));
        frame();
        check("blink_f6_off", 64'(num_data), 64'(ALL_A));
        blink_idx = 4'hF;
        #1;
        check("blink_idx_lag", 64'(num_data), 64'(ALL_A));
        tick();
        check("blink_none",    64'(num_data), 64'(44'hAAAAAAA2AAA));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
